// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the 3-bit-funct combinational ALU.
// Handles one instruction at a time and writes back before the next accept, so no forwarding is needed.
module alu_issue_ctrl #(
    parameter int NREGS = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_instr_valid,
    output logic             o_instr_ready,
    input  logic [15:0]      i_instr,
    output logic [2:0]       o_alu_funct,
    output logic [WIDTH-1:0] o_alu_data1,
    output logic [WIDTH-1:0] o_alu_data2,
    input  logic [WIDTH-1:0] i_alu_out,
    input  logic             i_alu_zero,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [WIDTH-1:0] o_res_data,
    output logic [2:0]       o_res_rd,
    output logic             o_res_wen,
    output logic             o_flag_z,
    input  logic [2:0]       i_dbg_addr,
    output logic [WIDTH-1:0] o_dbg_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_LI  = 3'b111;

    logic [1:0]       r_state;
    logic [2:0]       r_op;
    logic [2:0]       r_rd;
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic [WIDTH-1:0] r_resData;
    logic             r_z;
    logic             r_flagZ;
    logic [WIDTH-1:0] r_regs [NREGS];

    logic [2:0]       w_op;
    logic [2:0]       w_rd;
    logic [2:0]       w_rs;
    logic [2:0]       w_rt;
    logic [9:0]       w_imm;
    logic [WIDTH-1:0] w_rsData;
    logic [WIDTH-1:0] w_rtData;
    logic             w_accept;
    logic             w_resWen;
    logic             w_inExec;

    assign w_op  = i_instr[15:13];
    assign w_rd  = i_instr[12:10];
    assign w_rs  = i_instr[9:7];
    assign w_rt  = i_instr[6:4];
    assign w_imm = i_instr[9:0];

    // r0 reads as zero regardless of storage contents.
    assign w_rsData = (w_rs == 3'd0) ? '0 : r_regs[w_rs];
    assign w_rtData = (w_rt == 3'd0) ? '0 : r_regs[w_rt];

    assign o_instr_ready = (r_state == S_IDLE) && !reset;
    assign w_accept      = i_instr_valid && o_instr_ready;
    assign w_resWen      = (r_op != OP_NOP) && (r_rd != 3'd0);
    assign w_inExec      = (r_state == S_EXEC);

    // The ALU sees zeros outside EXEC so its output idles at 0.
    assign o_alu_funct = !w_inExec ? 3'b000 : ((r_op == OP_LI) ? 3'b100 : r_op);
    assign o_alu_data1 = w_inExec ? r_opA : '0;
    assign o_alu_data2 = w_inExec ? r_opB : '0;

    assign o_res_valid = (r_state == S_WB);
    assign o_res_data  = r_resData;
    assign o_res_rd    = r_rd;
    assign o_res_wen   = o_res_valid && w_resWen;
    assign o_flag_z    = r_flagZ;
    assign o_dbg_data  = (i_dbg_addr == 3'd0) ? '0 : r_regs[i_dbg_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= OP_NOP;
            r_rd      <= 3'd0;
            r_opA     <= '0;
            r_opB     <= '0;
            r_resData <= '0;
            r_z       <= 1'b0;
            r_flagZ   <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_op;
                        r_rd    <= w_rd;
                        r_opA   <= (w_op == OP_LI) ? {{(WIDTH-10){1'b0}}, w_imm} : w_rsData;
                        r_opB   <= ((w_op == OP_LI) || (w_op == OP_NOT)) ? '0 : w_rtData;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_resData <= i_alu_out;
                    r_z       <= i_alu_zero;
                    r_state   <= S_WB;
                end
                S_WB: begin
                    if (i_res_ready) begin
                        if (w_resWen) begin
                            r_regs[r_rd] <= r_resData;
                        end
                        if (r_op != OP_NOP) begin
                            r_flagZ <= r_z;
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        i_instr_valid;
    logic        o_instr_ready;
    logic [15:0] i_instr;
    logic [2:0]  o_alu_funct;
    logic [31:0] o_alu_data1;
    logic [31:0] o_alu_data2;
    logic [31:0] i_alu_out;
    logic        i_alu_zero;
    logic        o_res_valid;
    logic        i_res_ready;
    logic [31:0] o_res_data;
    logic [2:0]  o_res_rd;
    logic        o_res_wen;
    logic        o_flag_z;
    logic [2:0]  i_dbg_addr;
    logic [31:0] o_dbg_data;

    int checks = 0;
    int passes = 0;

    logic [2:0]  exFunct;
    logic [31:0] exD1;
    logic [31:0] exD2;
    logic        exValid;
    logic        wbValid;
    logic [31:0] wbData;
    logic [2:0]  wbRd;
    logic        wbWen;
    logic [2:0]  wbFunct;

    alu_issue_ctrl #(.NREGS(8), .WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .i_instr_valid(i_instr_valid), .o_instr_ready(o_instr_ready), .i_instr(i_instr),
        .o_alu_funct(o_alu_funct), .o_alu_data1(o_alu_data1), .o_alu_data2(o_alu_data2),
        .i_alu_out(i_alu_out), .i_alu_zero(i_alu_zero),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_data(o_res_data),
        .o_res_rd(o_res_rd), .o_res_wen(o_res_wen), .o_flag_z(o_flag_z),
        .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: the team's 3-bit funct encoding.
    always_comb begin
        case (o_alu_funct)
            3'b001:  i_alu_out = o_alu_data1 + o_alu_data2;
            3'b010:  i_alu_out = o_alu_data1 - o_alu_data2;
            3'b011:  i_alu_out = o_alu_data1 & o_alu_data2;
            3'b100:  i_alu_out = o_alu_data1 | o_alu_data2;
            3'b101:  i_alu_out = ~o_alu_data1;
            3'b110:  i_alu_out = o_alu_data1 ^ o_alu_data2;
            default: i_alu_out = 32'h0;
        endcase
        i_alu_zero = (i_alu_out == 32'h0);
    end

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 4'b0000};
    endfunction

    function automatic logic [15:0] encLi(input logic [2:0] rd, input logic [9:0] imm);
        return {3'b111, rd, imm};
    endfunction

    // Offers one instruction, samples the EXEC cycle, and returns at the first WB negedge.
    task automatic issue(input logic [15:0] ins);
        int waitCnt;
        @(negedge clk);
        i_instr       = ins;
        i_instr_valid = 1'b1;
        waitCnt = 0;
        while (!o_instr_ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!o_instr_ready) begin
            checks++;
            $display("[TB] FAIL accept_timeout: instr_ready got %b want 1", o_instr_ready);
        end
        @(posedge clk);
        @(negedge clk);
        i_instr_valid = 1'b0;
        exFunct = o_alu_funct;
        exD1    = o_alu_data1;
        exD2    = o_alu_data2;
        exValid = o_res_valid;
        @(negedge clk);
        wbValid = o_res_valid;
        wbData  = o_res_data;
        wbRd    = o_res_rd;
        wbWen   = o_res_wen;
        wbFunct = o_alu_funct;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (o_instr_ready !== 1'b0) $display("[TB] FAIL ready_in_reset: got %b want 0", o_instr_ready); else passes++;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (o_instr_ready !== 1'b1) $display("[TB] FAIL ready_after_reset: got %b want 1", o_instr_ready); else passes++;
        checks++; if (o_flag_z !== 1'b0) $display("[TB] FAIL flag_reset: got %b want 0", o_flag_z); else passes++;
        checks++; if ({o_res_valid, o_res_wen, o_res_rd} !== 5'b0) $display("[TB] FAIL res_ctrl_reset: got %b want 0", {o_res_valid, o_res_wen, o_res_rd}); else passes++;
        checks++; if (o_res_data !== 32'h0) $display("[TB] FAIL res_data_reset: got %h want 0", o_res_data); else passes++;
        checks++; if ({o_alu_funct, o_alu_data1, o_alu_data2} !== 67'h0) $display("[TB] FAIL alu_idle_reset: got %h want 0", {o_alu_funct, o_alu_data1, o_alu_data2}); else passes++;
        for (int a = 0; a < 8; a++) begin
            i_dbg_addr = 3'(a);
            #1;
            checks++; if (o_dbg_data !== 32'h0) $display("[TB] FAIL dbg_reset r%0d: got %h want 0", a, o_dbg_data); else passes++;
        end
    endtask

    task automatic test_li_add;
        issue(encLi(3'd1, 10'd5));
        checks++; if ({exFunct, exD1, exD2} !== {3'b100, 32'd5, 32'd0}) $display("[TB] FAIL li_exec: got %h want %h", {exFunct, exD1, exD2}, {3'b100, 32'd5, 32'd0}); else passes++;
        checks++; if ({exValid, wbValid} !== 2'b01) $display("[TB] FAIL latency: got %b want 01", {exValid, wbValid}); else passes++;
        checks++; if ({wbData, wbRd, wbWen} !== {32'd5, 3'd1, 1'b1}) $display("[TB] FAIL li_r1: got %h want %h", {wbData, wbRd, wbWen}, {32'd5, 3'd1, 1'b1}); else passes++;
        issue(encLi(3'd2, 10'd3));
        checks++; if (wbData !== 32'd3) $display("[TB] FAIL li_r2: got %h want 3", wbData); else passes++;
        issue(enc(3'b001, 3'd3, 3'd1, 3'd2));
        checks++; if ({exFunct, exD1, exD2} !== {3'b001, 32'd5, 32'd3}) $display("[TB] FAIL add_exec: got %h want %h", {exFunct, exD1, exD2}, {3'b001, 32'd5, 32'd3}); else passes++;
        checks++; if (wbFunct !== 3'b000) $display("[TB] FAIL alu_idle_wb: got %b want 000", wbFunct); else passes++;
        checks++; if ({wbData, wbRd} !== {32'd8, 3'd3}) $display("[TB] FAIL add_res: got %h want %h", {wbData, wbRd}, {32'd8, 3'd3}); else passes++;
        @(negedge clk);
        i_dbg_addr = 3'd3;
        #1;
        checks++; if (o_dbg_data !== 32'd8) $display("[TB] FAIL r3_value: got %h want 8", o_dbg_data); else passes++;
        checks++; if ({o_alu_funct, o_alu_data1} !== 35'h0) $display("[TB] FAIL alu_idle_after: got %h want 0", {o_alu_funct, o_alu_data1}); else passes++;
    endtask

    task automatic test_flags;
        issue(enc(3'b010, 3'd4, 3'd1, 3'd1));
        checks++; if (wbData !== 32'd0) $display("[TB] FAIL sub_res: got %h want 0", wbData); else passes++;
        @(negedge clk);
        checks++; if (o_flag_z !== 1'b1) $display("[TB] FAIL sub_flag: got %b want 1", o_flag_z); else passes++;
        issue(enc(3'b110, 3'd5, 3'd1, 3'd2));
        checks++; if (wbData !== 32'd6) $display("[TB] FAIL xor_res: got %h want 6", wbData); else passes++;
        @(negedge clk);
        checks++; if (o_flag_z !== 1'b0) $display("[TB] FAIL xor_flag: got %b want 0", o_flag_z); else passes++;
    endtask

    task automatic test_not_wrap;
        issue(enc(3'b101, 3'd6, 3'd0, 3'd1));
        checks++; if ({exFunct, exD1, exD2} !== {3'b101, 32'd0, 32'd0}) $display("[TB] FAIL not_exec: got %h want %h", {exFunct, exD1, exD2}, {3'b101, 32'd0, 32'd0}); else passes++;
        checks++; if (wbData !== 32'hFFFF_FFFF) $display("[TB] FAIL not_res: got %h want ffffffff", wbData); else passes++;
        issue(enc(3'b001, 3'd7, 3'd6, 3'd1));
        checks++; if (wbData !== 32'd4) $display("[TB] FAIL add_wrap: got %h want 4", wbData); else passes++;
        @(negedge clk);
        i_dbg_addr = 3'd7;
        #1;
        checks++; if (o_dbg_data !== 32'd4) $display("[TB] FAIL r7_value: got %h want 4", o_dbg_data); else passes++;
    endtask

    task automatic test_r0_nop;
        issue(enc(3'b010, 3'd0, 3'd1, 3'd2));
        checks++; if ({wbData, wbRd, wbWen} !== {32'd2, 3'd0, 1'b0}) $display("[TB] FAIL sub_r0: got %h want %h", {wbData, wbRd, wbWen}, {32'd2, 3'd0, 1'b0}); else passes++;
        @(negedge clk);
        i_dbg_addr = 3'd0;
        #1;
        checks++; if (o_dbg_data !== 32'd0) $display("[TB] FAIL r0_value: got %h want 0", o_dbg_data); else passes++;
        checks++; if (o_flag_z !== 1'b0) $display("[TB] FAIL r0_flag: got %b want 0", o_flag_z); else passes++;
        issue(enc(3'b000, 3'd3, 3'd0, 3'd0));
        checks++; if ({wbValid, wbWen} !== 2'b10) $display("[TB] FAIL nop_wen: got %b want 10", {wbValid, wbWen}); else passes++;
        @(negedge clk);
        checks++; if (o_flag_z !== 1'b0) $display("[TB] FAIL nop_flag: got %b want 0", o_flag_z); else passes++;
        i_dbg_addr = 3'd3;
        #1;
        checks++; if (o_dbg_data !== 32'd8) $display("[TB] FAIL nop_r3: got %h want 8", o_dbg_data); else passes++;
    endtask

    task automatic test_back_to_back_stall;
        i_res_ready = 1'b0;
        i_dbg_addr  = 3'd2;
        issue(enc(3'b001, 3'd2, 3'd1, 3'd1));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if ({o_res_valid, o_instr_ready, o_res_wen, o_res_rd, o_res_data} !== {1'b1, 1'b0, 1'b1, 3'd2, 32'd10})
                $display("[TB] FAIL stall_hold c%0d: got %h want %h", c, {o_res_valid, o_instr_ready, o_res_wen, o_res_rd, o_res_data}, {1'b1, 1'b0, 1'b1, 3'd2, 32'd10});
            else passes++;
            checks++; if (o_dbg_data !== 32'd3) $display("[TB] FAIL stall_nowrite c%0d: got %h want 3", c, o_dbg_data); else passes++;
        end
        i_res_ready = 1'b1;
        @(negedge clk);
        checks++; if ({o_res_valid, o_instr_ready} !== 2'b01) $display("[TB] FAIL stall_release: got %b want 01", {o_res_valid, o_instr_ready}); else passes++;
        checks++; if (o_dbg_data !== 32'd10) $display("[TB] FAIL stall_write: got %h want 0000000a", o_dbg_data); else passes++;
    endtask

    task automatic test_reset_abort;
        @(negedge clk);
        i_instr       = enc(3'b001, 3'd1, 3'd1, 3'd1);
        i_instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_instr_valid = 1'b0;
        checks++; if (o_alu_funct !== 3'b001) $display("[TB] FAIL abort_in_exec: got %b want 001", o_alu_funct); else passes++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        i_dbg_addr = 3'd1;
        #1;
        checks++; if ({o_res_valid, o_flag_z, o_dbg_data} !== 34'h0) $display("[TB] FAIL abort_state: got %h want 0", {o_res_valid, o_flag_z, o_dbg_data}); else passes++;
        @(negedge clk);
        checks++; if ({o_instr_ready, o_res_valid} !== 2'b10) $display("[TB] FAIL abort_idle: got %b want 10", {o_instr_ready, o_res_valid}); else passes++;
        issue(encLi(3'd1, 10'h3FF));
        checks++; if ({wbData, wbRd} !== {32'h3FF, 3'd1}) $display("[TB] FAIL restart_li: got %h want %h", {wbData, wbRd}, {32'h3FF, 3'd1}); else passes++;
        @(negedge clk);
        #1;
        checks++; if (o_dbg_data !== 32'h3FF) $display("[TB] FAIL restart_r1: got %h want 3ff", o_dbg_data); else passes++;
    endtask

    initial begin
        reset         = 1'b1;
        i_instr_valid = 1'b0;
        i_instr       = 16'h0;
        i_res_ready   = 1'b1;
        i_dbg_addr    = 3'd0;
        test_reset();
        test_li_add();
        test_flags();
        test_not_wrap();
        test_r0_nop();
        test_back_to_back_stall();
        test_reset_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
